// File: rtl/ipu_input_ctrl.sv
// IPU front end: debounces five buttons, moves a cursor over a 3x3 grid and raises
// an ipu_int/int_ack handshake carrying the selected cell. Optional macro: IPU_OCCUPANCY_EN.
module ipu_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       int_ack,
  input  logic       clear_board,
  output logic       ipu_int,
  output logic [3:0] grid_coord,
  output logic [3:0] cursor,
  output logic [8:0] occupied
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  logic [4:0] raw;
  logic [4:0] evt;
  assign raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  // One synchronizer, debounce counter and rising-edge event per button.
  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    logic          sync1_reg;
    logic          sync2_reg;
    logic          deb_reg;
    logic          deb_prev_reg;
    logic          evt_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_reg    <= 1'b0;
        sync2_reg    <= 1'b0;
        deb_reg      <= 1'b0;
        deb_prev_reg <= 1'b0;
        evt_reg      <= 1'b0;
        cnt_reg      <= '0;
      end else begin
        sync1_reg    <= raw[gi];
        sync2_reg    <= sync1_reg;
        deb_prev_reg <= deb_reg;
        evt_reg      <= deb_reg & ~deb_prev_reg;
        if (sync2_reg == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          deb_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign evt[gi] = evt_reg;
  end

  logic       up_evt;
  logic       down_evt;
  logic       left_evt;
  logic       right_evt;
  logic       sel_evt;
  assign up_evt    = evt[0];
  assign down_evt  = evt[1];
  assign left_evt  = evt[2];
  assign right_evt = evt[3];
  assign sel_evt   = evt[4];

  logic [1:0] row_reg;
  logic [1:0] row_next;
  logic [1:0] col_reg;
  logic [1:0] col_next;

  // Opposing moves in the same cycle cancel; edges saturate.
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (up_evt && !down_evt && row_reg != 2'd0) row_next = row_reg - 2'd1;
    if (down_evt && !up_evt && row_reg != 2'd2) row_next = row_reg + 2'd1;
    if (left_evt && !right_evt && col_reg != 2'd0) col_next = col_reg - 2'd1;
    if (right_evt && !left_evt && col_reg != 2'd2) col_next = col_reg + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg <= 2'd1;
      col_reg <= 2'd1;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  assign cursor = ({2'b00, row_reg} * 4'd3) + {2'b00, col_reg};

  state_t     state_reg;
  state_t     state_next;
  logic       ack_reg;
  logic       latch_coord;
  logic       eligible;
  logic [3:0] grid_coord_reg;

  always_comb begin
    state_next  = state_reg;
    latch_coord = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (sel_evt && eligible) begin
          latch_coord = 1'b1;
          state_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_reg) state_next = ST_REL;
      end
      ST_REL: begin
        if (!ack_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // int_ack is registered once, so the FSM reacts one edge after it is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      ack_reg        <= 1'b0;
      grid_coord_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= int_ack;
      if (latch_coord) grid_coord_reg <= cursor;
    end
  end

  assign ipu_int    = (state_reg == ST_REQ);
  assign grid_coord = grid_coord_reg;

`ifdef IPU_OCCUPANCY_EN
  logic [8:0] occ_reg;

  // Cell is marked when the processor acknowledges; clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg <= 9'd0;
    end else if (clear_board) begin
      occ_reg <= 9'd0;
    end else if (state_reg == ST_REQ && ack_reg) begin
      occ_reg[grid_coord_reg] <= 1'b1;
    end
  end

  assign occupied = occ_reg;
  assign eligible = ~occ_reg[cursor];
`else
  logic unused_clear;
  assign unused_clear = clear_board;
  assign occupied     = 9'd0;
  assign eligible     = 1'b1;
`endif

endmodule

// File: tb/tb_ipu_input_ctrl.sv
// Scoreboard bench for ipu_input_ctrl: stimulus pushes expected requests and cursor
// moves into queues; a negedge monitor pops and compares when the DUT presents them.
module tb_ipu_input_ctrl;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic       int_ack = 1'b0;
  logic       clear_board = 1'b0;
  logic       ipu_int;
  logic [3:0] grid_coord;
  logic [3:0] cursor;
  logic [8:0] occupied;

  ipu_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel),
    .int_ack(int_ack), .clear_board(clear_board),
    .ipu_int(ipu_int), .grid_coord(grid_coord), .cursor(cursor), .occupied(occupied)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t req_q[$];
  exp_t cur_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   cur_model = 4;
  bit   mon_en = 1'b0;
  logic prev_int = 1'b0;
  logic [3:0] prev_cur = 4'd4;

  localparam logic [4:0] M_UP = 5'b00001, M_DN = 5'b00010, M_LT = 5'b00100,
                         M_RT = 5'b01000, M_SEL = 5'b10000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every rising ipu_int and every cursor change must match a queued entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ipu_int && !prev_int) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = req_q.pop_front();
          check("req_coord", int'(grid_coord), e.val);
          check("req_cycle", cyc, e.cyc);
          $display("req   coord=%0d cyc=%0d", grid_coord, cyc);
        end
      end
      if (cursor != prev_cur) begin
        if (cur_q.size() == 0) begin
          check("cursor_unexpected", int'(cursor), int'(prev_cur));
        end else begin
          exp_t e;
          e = cur_q.pop_front();
          check("cursor_value", int'(cursor), e.val);
          check("cursor_cycle", cyc, e.cyc);
          $display("move  cursor=%0d cyc=%0d", cursor, cyc);
        end
      end
    end
    prev_int <= ipu_int;
    prev_cur <= cursor;
  end

  // Raw press at negedge (cyc=c): first sampled at c+1, response visible after edge c+4+D.
  task automatic press(input logic [4:0] mask, input int exp_cur, input int exp_req);
    exp_t e;
    @(negedge clk);
    if (exp_cur != cur_model) begin
      e.val = exp_cur; e.cyc = cyc + 4 + D;
      cur_q.push_back(e);
      cur_model = exp_cur;
    end
    if (exp_req >= 0) begin
      e.val = exp_req; e.cyc = cyc + 4 + D;
      req_q.push_back(e);
    end
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = mask;
    repeat (2 * D) @(negedge clk);
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = 5'b0;
    repeat (2 * D + 4) @(negedge clk);
    check("cursor_after_press", int'(cursor), exp_cur);
  endtask

  // One-cycle ack: ipu_int still high after the sampling edge, low one edge later.
  task automatic ack_pulse(input bit do_clear);
    @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    check("ack_int_still_high", int'(ipu_int), 1);
    @(negedge clk);
    check("ack_int_dropped", int'(ipu_int), 0);
    repeat (2) @(negedge clk);
    if (do_clear) begin
      clear_board = 1'b1;
      @(negedge clk);
      clear_board = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ipu_int", int'(ipu_int), 0);
    check("rst_grid_coord", int'(grid_coord), 0);
    check("rst_cursor", int'(cursor), 4);
    check("rst_occupied", int'(occupied), 0);
    mon_en = 1'b1;

    // Cursor moves with saturation at col 2
    press(M_RT, 5, -1);
    press(M_RT, 5, -1);
    press(M_RT, 5, -1);
    press(M_DN, 8, -1);
    press(M_UP, 5, -1);
    press(M_LT, 4, -1);
    press(M_UP | M_DN, 4, -1);
    press(M_RT | M_DN, 8, -1);
    press(M_UP | M_LT, 4, -1);

    // Select, then a one-cycle ack
    press(M_SEL, 4, 4);
    check("req_held_coord", int'(grid_coord), 4);
`ifdef IPU_OCCUPANCY_EN
    ack_pulse(1'b0);
    check("occ_set", int'(occupied), 'h010);
    press(M_SEL, 4, -1);
    check("occ_sel_dropped", int'(ipu_int), 0);
    clear_board = 1'b1;
    @(negedge clk);
    clear_board = 1'b0;
    check("occ_cleared", int'(occupied), 0);
    press(M_SEL, 4, 4);
    ack_pulse(1'b1);
`else
    ack_pulse(1'b1);
`endif

    // Held ack while a second select arrives in REL: it must be dropped
    press(M_SEL, 4, 4);
    @(negedge clk);
    int_ack = 1'b1;
    btn_sel = 1'b1;
    @(negedge clk);
    check("hold_int_still_high", int'(ipu_int), 1);
    @(negedge clk);
    check("hold_int_dropped", int'(ipu_int), 0);
    repeat (D + 6) @(negedge clk);
    int_ack = 1'b0;
    repeat (2 * D) @(negedge clk);
    btn_sel = 1'b0;
    repeat (2 * D + 4) @(negedge clk);
    check("hold_no_new_req", int'(ipu_int), 0);
    clear_board = 1'b1;
    @(negedge clk);
    clear_board = 1'b0;

    // Bouncing select never settles long enough
    for (int i = 0; i < 25; i++) begin
      btn_sel = (i % 2 == 0);
      repeat (D / 2) @(negedge clk);
    end
    btn_sel = 1'b0;
    repeat (2 * D + 4) @(negedge clk);
    check("bounce_no_req", int'(ipu_int), 0);

    // Reset in REQ loses the request; a later ack is ignored
    press(M_SEL, 4, 4);
    check("pre_rst_int", int'(ipu_int), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ipu_int", int'(ipu_int), 0);
    check("midrst_grid_coord", int'(grid_coord), 0);
    check("midrst_cursor", int'(cursor), 4);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("postrst_ack_ignored", int'(ipu_int), 0);
    check("final_occupied", int'(occupied), 0);

    repeat (2) @(negedge clk);
    check("req_q_drained", req_q.size(), 0);
    check("cur_q_drained", cur_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
